fabric_loader: RTL

//  Upstream feeder of the fabric. Buffers instruction words from the host, steers each one onto
//  its row's instruction bus, then launches the selected rows via call and tracks their ret to

---
 rtl/fabric_loader_pkg.sv | 24 ++
 rtl/fabric_loader_fifo.sv | 52 +++++
 rtl/fabric_loader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fabric_loader_pkg.sv
// fabric_loader shared types: instruction packet, FSM state, row geometry.
// Optional watchdog macro: FABRIC_LOADER_TIMEOUT_EN.
package fabric_loader_pkg;

  localparam int ROWS             = 2;
  localparam int INSTR_DATA_WIDTH = 32;
  localparam int INSTR_ADDR_WIDTH = 4;
  localparam int INSTR_HOPS_WIDTH = 4;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef struct packed {
    logic [ROW_W-1:0]            row;
    logic [INSTR_ADDR_WIDTH-1:0] addr;
    logic [INSTR_HOPS_WIDTH-1:0] hops;
    logic [INSTR_DATA_WIDTH-1:0] data;
  } instr_pkt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALL = 2'd1,
    WAIT = 2'd2
  } loader_state_e;

endpackage

// File: rtl/fabric_loader_fifo.sv
// fabric_loader instruction buffer: synchronous FIFO of instr_pkt_t.
// Optional watchdog macro (top only): FABRIC_LOADER_TIMEOUT_EN.
module fabric_loader_fifo
  import fabric_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  instr_pkt_t                 wdata,
  input  logic                       pop,
  output instr_pkt_t                 rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  instr_pkt_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // pointers wrap for free since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fabric_loader.sv
// fabric_loader: buffers host instructions, steers them to rows, launches call/ret.
// Optional watchdog macro: FABRIC_LOADER_TIMEOUT_EN.
module fabric_loader
  import fabric_loader_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ROW_W-1:0]                   in_row,
  input  logic [INSTR_ADDR_WIDTH-1:0]        in_addr,
  input  logic [INSTR_HOPS_WIDTH-1:0]        in_hops,
  input  logic [INSTR_DATA_WIDTH-1:0]        in_data,
  input  logic                               start_valid,
  output logic                               start_ready,
  input  logic [ROWS-1:0]                    start_mask,
  output logic                               busy,
  output logic                               done,
  output logic                               timeout_err,
  output logic [ROWS-1:0]                    call,
  input  logic [ROWS-1:0]                    ret,
  output logic [ROWS*INSTR_DATA_WIDTH-1:0]   instr_data_in,
  output logic [ROWS*INSTR_ADDR_WIDTH-1:0]   instr_addr_in,
  output logic [ROWS*INSTR_HOPS_WIDTH-1:0]   instr_hops_in,
  output logic [ROWS-1:0]                    instr_en_in
);

  loader_state_e state_q, state_d;

  instr_pkt_t                  pkt_in;
  instr_pkt_t                  pkt_out;
  logic                        push;
  logic                        pop;
  logic                        full;
  logic                        empty;
  logic [$clog2(FIFO_DEPTH):0] count;

  logic [ROWS-1:0] mask_q;
  logic            settled_q;
  logic            done_q;
  logic            start_fire;
  logic            ret_ok;
  logic            wd_expired;

  assign pkt_in = '{row: in_row, addr: in_addr,
                    hops: in_hops, data: in_data};

  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty;

  fabric_loader_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (pkt_in),
    .pop   (pop),
    .rdata (pkt_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // row demux: one strobe per popped entry, idle rows read zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_en_in   <= '0;
      instr_data_in <= '0;
      instr_addr_in <= '0;
      instr_hops_in <= '0;
    end else begin
      instr_en_in   <= '0;
      instr_data_in <= '0;
      instr_addr_in <= '0;
      instr_hops_in <= '0;
      if (pop) begin
        instr_en_in[pkt_out.row] <= 1'b1;
        instr_data_in[pkt_out.row*INSTR_DATA_WIDTH +: INSTR_DATA_WIDTH]
          <= pkt_out.data;
        instr_addr_in[pkt_out.row*INSTR_ADDR_WIDTH +: INSTR_ADDR_WIDTH]
          <= pkt_out.addr;
        instr_hops_in[pkt_out.row*INSTR_HOPS_WIDTH +: INSTR_HOPS_WIDTH]
          <= pkt_out.hops;
      end
    end
  end

  assign start_fire = start_valid && start_ready;
  assign ret_ok     = (state_q == WAIT) && settled_q &&
                      ((ret & mask_q) == mask_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_fire && start_mask != '0) state_d = CALL;
      CALL:    state_d = WAIT;
      WAIT:    if (ret_ok || wd_expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // start waits until every buffered word has reached its row
  always_comb begin
    start_ready = rst_n && (state_q == IDLE) && (count == '0) &&
                  !(|instr_en_in) && !in_valid;
    call        = (rst_n && state_q == CALL) ? mask_q : '0;
    busy        = rst_n && ((state_q != IDLE) || !empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q    <= '0;
      settled_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (start_fire) mask_q <= start_mask;
      settled_q <= (state_q == WAIT);
      done_q    <= (start_fire && start_mask == '0) ||
                   ret_ok || wd_expired;
    end
  end

  assign done = done_q;

`ifdef FABRIC_LOADER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt;
  logic          err_q;

  // wd_cnt holds the 1-based index of the current WAIT cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == CALL)      wd_cnt <= CW'(1);
      else if (state_q == WAIT) wd_cnt <= wd_cnt + 1'b1;
      if (wd_expired) err_q <= 1'b1;
    end
  end

  assign wd_expired  = (state_q == WAIT) && !ret_ok &&
                       (wd_cnt == CW'(TIMEOUT_CYCLES));
  assign timeout_err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule
